apu_frame_sequencer: RTL

//  Frame sequencer for the NES APU: counts CPU-rate enables and issues quarter-frame and half-frame strobes.

---
 rtl/apu_pkg.sv | 18 +
 rtl/apu_frame_step_decode.sv | 35 +++
 rtl/apu_frame_sequencer.sv | 135 +++++++++++++
 3 files changed

// File: rtl/apu_pkg.sv
// Shared definitions for the APU frame sequencer.
// NTSC step constants (in CPU-rate enables), default restart delay after a
// $4017 write, and the sequencer state encoding.
package apu_pkg;

  localparam int unsigned STEP1_NTSC          = 7457;
  localparam int unsigned STEP2_NTSC          = 14913;
  localparam int unsigned STEP3_NTSC          = 22371;
  localparam int unsigned STEP4_NTSC          = 29829;
  localparam int unsigned STEP5_NTSC          = 37281;
  localparam int unsigned WRITE_DELAY_DEFAULT = 3;

  typedef enum logic {
    RUN     = 1'b0,
    PENDING = 1'b1
  } seqState_t;

endpackage

// File: rtl/apu_frame_step_decode.sv
// Combinational step decode for the frame sequencer.
// Ports:
//   iCount   - current sequencer count
//   iMode    - 0 = 4-step, 1 = 5-step
//   oQuarter - quarter-frame event at this count
//   oHalf    - half-frame event at this count
//   oIrqSet  - frame IRQ request (4-step final step only; inhibit applied by caller)
module apu_frame_step_decode #(
  parameter int unsigned STEP1 = 7457,
  parameter int unsigned STEP2 = 14913,
  parameter int unsigned STEP3 = 22371,
  parameter int unsigned STEP4 = 29829,
  parameter int unsigned STEP5 = 37281
) (
  input  logic [15:0] iCount,
  input  logic        iMode,
  output logic        oQuarter,
  output logic        oHalf,
  output logic        oIrqSet
);

  logic atStep1, atStep2, atStep3, atLast4, atLast5;

  assign atStep1 = (iCount == 16'(STEP1));
  assign atStep2 = (iCount == 16'(STEP2));
  assign atStep3 = (iCount == 16'(STEP3));
  // STEP4 is only an event in 4-step mode; 5-step passes through it silently.
  assign atLast4 = (iCount == 16'(STEP4)) && !iMode;
  assign atLast5 = (iCount == 16'(STEP5)) && iMode;

  assign oQuarter = atStep1 || atStep2 || atStep3 || atLast4 || atLast5;
  assign oHalf    = atStep2 || atLast4 || atLast5;
  assign oIrqSet  = atLast4;

endmodule

// File: rtl/apu_frame_sequencer.sv
// NES APU frame sequencer: counts CPU-rate enables and issues quarter/half
// frame strobes, implements $4017 mode/inhibit writes with delayed restart,
// and the frame IRQ flag.
// Ports:
//   iClk, iReset  - clock, async active-high reset
//   iCpuCE        - one-cycle pulse per CPU cycle, qualifies all counting
//   iWrite4017    - one-cycle pulse, CPU write to $4017
//   iData[1:0]    - [1] mode (1 = 5-step), [0] IRQ inhibit
//   iIrqAck       - one-cycle pulse, $4015 read clears frame IRQ
//   oQuarterFrame - one-cycle quarter-frame strobe
//   oHalfFrame    - one-cycle half-frame strobe
//   oIrq          - frame IRQ level
//   oMode         - current mode
//
// state   | meaning
// RUN     | normal counting and event decode
// PENDING | $4017 written; counting continues, restart after delay CEs
module apu_frame_sequencer
  import apu_pkg::*;
#(
  parameter int unsigned STEP1       = STEP1_NTSC,
  parameter int unsigned STEP2       = STEP2_NTSC,
  parameter int unsigned STEP3       = STEP3_NTSC,
  parameter int unsigned STEP4       = STEP4_NTSC,
  parameter int unsigned STEP5       = STEP5_NTSC,
  parameter int unsigned WRITE_DELAY = WRITE_DELAY_DEFAULT
) (
  input  logic       iClk,
  input  logic       iReset,
  input  logic       iCpuCE,
  input  logic       iWrite4017,
  input  logic [1:0] iData,
  input  logic       iIrqAck,
  output logic       oQuarterFrame,
  output logic       oHalfFrame,
  output logic       oIrq,
  output logic       oMode
);

  localparam logic [15:0] TERM4 = 16'(STEP4);
  localparam logic [15:0] TERM5 = 16'(STEP5);
  localparam logic [2:0]  DELAY = 3'(WRITE_DELAY);

  seqState_t   state, stateNext;
  logic [15:0] count, countNext;
  logic [2:0]  delay, delayNext;
  logic        mode, modeNext;
  logic        inhibit, inhibitNext;
  logic        irq, irqNext;
  logic        qNext, hNext;
  logic        decQ, decH, decIrq;
  logic        restartCe, irqSetNow;

  apu_frame_step_decode #(
    .STEP1(STEP1), .STEP2(STEP2), .STEP3(STEP3), .STEP4(STEP4), .STEP5(STEP5)
  ) uDecode (
    .iCount  (count),
    .iMode   (mode),
    .oQuarter(decQ),
    .oHalf   (decH),
    .oIrqSet (decIrq)
  );

  // A write landing on the restart CE reloads the delay instead of restarting.
  assign restartCe = iCpuCE && (state == PENDING) && (delay == 3'd1) && !iWrite4017;
  assign irqSetNow = iCpuCE && !restartCe && decIrq && !inhibit;

  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      state         <= RUN;
      count         <= '0;
      delay         <= '0;
      mode          <= 1'b0;
      inhibit       <= 1'b0;
      irq           <= 1'b0;
      oQuarterFrame <= 1'b0;
      oHalfFrame    <= 1'b0;
    end else begin
      state         <= stateNext;
      count         <= countNext;
      delay         <= delayNext;
      mode          <= modeNext;
      inhibit       <= inhibitNext;
      irq           <= irqNext;
      oQuarterFrame <= qNext;
      oHalfFrame    <= hNext;
    end
  end

  always_comb begin
    stateNext   = state;
    countNext   = count;
    delayNext   = delay;
    modeNext    = mode;
    inhibitNext = inhibit;
    qNext       = 1'b0;
    hNext       = 1'b0;

    if (restartCe) begin
      countNext = '0;
      stateNext = RUN;
      qNext     = mode;
      hNext     = mode;
    end else if (iCpuCE) begin
      countNext = (count == (mode ? TERM5 : TERM4)) ? 16'd0 : count + 16'd1;
      qNext     = decQ;
      hNext     = decH;
      if (state == PENDING && !iWrite4017) begin
        delayNext = delay - 3'd1;
      end
    end

    if (iWrite4017) begin
      modeNext    = iData[1];
      inhibitNext = iData[0];
      delayNext   = DELAY;
      stateNext   = PENDING;
    end

    // Inhibit write beats a same-cycle set; a set beats a same-cycle ack.
    if (iWrite4017 && iData[0]) begin
      irqNext = 1'b0;
    end else if (irqSetNow) begin
      irqNext = 1'b1;
    end else if (iIrqAck) begin
      irqNext = 1'b0;
    end else begin
      irqNext = irq;
    end
  end

  assign oIrq  = irq;
  assign oMode = mode;

endmodule
